// File: rtl/uart_rx_os16.sv
// ---------------------------------------------------------------------------
// uart_rx_os16
//
// Serial-debug receive front end. Deserialises UART frames arriving on rxd
// into bytes for the debug command processor. The block runs on the
// 16x-baud clock, so one clk is 1/OVERSAMPLE of a bit period. Each received
// byte is offered on a valid/ready handshake through a 1-entry holding
// register.
//
// Optional feature macro: UART_RX_PARITY_EN
//   undefined : 8N1 frames, no parity state, par_err tied low
//   defined   : 8E1 frames, even parity over data + parity bit
//
// Parameters
//   OVERSAMPLE   clk cycles per bit (even, >= 4)
//   DATA_BITS    data bits per frame, LSB first
//   SYNC_STAGES  rxd synchroniser depth (>= 2)
//
// Ports
//   clk        in   16x-baud clock, rising edge
//   rst        in   synchronous reset, active-high
//   rxd        in   asynchronous serial line, idle high
//   d_rx       out  received byte, stable while vld_rx is high
//   vld_rx     out  byte available
//   rdy_rx     in   consumer accepts when vld_rx & rdy_rx
//   frame_err  out  1-cycle pulse, stop bit sampled low
//   ovr_err    out  1-cycle pulse, byte completed while holding reg full
//   par_err    out  1-cycle pulse, parity mismatch
// ---------------------------------------------------------------------------
module uart_rx_os16 #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] d_rx,
    output logic                 vld_rx,
    input  logic                 rdy_rx,
    output logic                 frame_err,
    output logic                 ovr_err,
    output logic                 par_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // The start bit is re-checked halfway through; every later bit is
    // sampled a full bit period after the previous sample, which lands
    // each sample near the middle of its bit.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic [2:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [BIT_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shreg;

    assign rxs = sync[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_err_q;
    logic par_ok;

    // Even parity: data bits plus the parity bit must XOR to zero.
    assign par_ok  = ~(^{shreg, par_bit});
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    // Synchroniser, frame FSM, holding register and error pulses. Error
    // outputs default low every cycle so each one is a single-cycle pulse.
    // The holding register is cleared on accept, but a byte completing on
    // the same edge overrides that so back-to-back traffic is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= '1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            d_rx      <= '0;
            vld_rx    <= 1'b0;
            frame_err <= 1'b0;
            ovr_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], rxd};
            frame_err <= 1'b0;
            ovr_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            if (vld_rx && rdy_rx) begin
                vld_rx <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        // A line that is high again mid start bit was a glitch.
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        // LSB arrives first, so shifting in from the top
                        // leaves bit 0 in the LSB after the last data bit.
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rxs;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        // Leaving mid stop bit keeps the receiver ready for a
                        // start edge that follows a single stop bit directly.
                        state <= IDLE;
                        if (!rxs) begin
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (!par_ok) begin
                            par_err_q <= 1'b1;
`endif
                        end else if (vld_rx && !rdy_rx) begin
                            ovr_err <= 1'b1;
                        end else begin
                            d_rx   <= shreg;
                            vld_rx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_os16
//
// Self-checking bench for uart_rx_os16. Frames are serialised onto rxd at
// 16 clk per bit. For each frame the bench records when its mid-stop
// decision is due and what it carries; a behavioural model then decides at
// that edge whether the byte is delivered, dropped with frame/parity error,
// or dropped with overrun, and tracks the holding register under the
// handshake. A compare process checks every DUT output against the model on
// every falling edge; directed sections add literal expectations.
// Build with +define+UART_RX_PARITY_EN to exercise the 8E1 variant.
// ---------------------------------------------------------------------------
module tb_uart_rx_os16;

`ifdef UART_RX_PARITY_EN
    localparam int NBITS  = 11;
    localparam int LAT    = 171;
`else
    localparam int NBITS  = 10;
    localparam int LAT    = 155;
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       rxd    = 1'b1;
    logic       rdy_rx = 1'b0;
    logic [7:0] d_rx;
    logic       vld_rx;
    logic       frame_err;
    logic       ovr_err;
    logic       par_err;

    uart_rx_os16 dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .d_rx      (d_rx),
        .vld_rx    (vld_rx),
        .rdy_rx    (rdy_rx),
        .frame_err (frame_err),
        .ovr_err   (ovr_err),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         stop_ok;
        bit         par_ok;
    } frame_t;

    frame_t     pend[$];
    int         cyc       = 0;
    logic       mvld      = 1'b0;
    logic [7:0] mdata     = 8'h00;
    logic       mferr     = 1'b0;
    logic       moerr     = 1'b0;
    logic       mperr     = 1'b0;
    int         n_checks  = 0;
    int         n_fail    = 0;
    bit         checking_on = 1'b0;

    int         vld_rises = 0;
    int         ovr_count = 0;
    int         ferr_count = 0;
    int         perr_count = 0;
    int         last_vld_rise = 0;
    int         last_start = 0;
    logic       prev_vld = 1'b0;

    // Reference model: at the edge a frame's stop decision is due, classify
    // it by priority (stop, parity, overrun) and update the holding register.
    always @(posedge clk) begin
        frame_t f;
        logic   was_vld;
        cyc++;
        mferr = 1'b0;
        moerr = 1'b0;
        mperr = 1'b0;
        if (rst) begin
            mvld  = 1'b0;
            mdata = 8'h00;
            pend.delete();
        end else begin
            was_vld = mvld;
            if (mvld && rdy_rx) mvld = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                f = pend.pop_front();
                if (!f.stop_ok)              mferr = 1'b1;
                else if (!f.par_ok)          mperr = 1'b1;
                else if (was_vld && !rdy_rx) moerr = 1'b1;
                else begin
                    mdata = f.data;
                    mvld  = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, actual, expected);
        end
    endtask

    // Per-cycle comparison against the model plus event counters used by
    // the directed sections.
    always @(negedge clk) begin
        if (checking_on) begin
            checkOutput("vld_rx",    {31'd0, vld_rx},    {31'd0, mvld});
            checkOutput("d_rx",      {24'd0, d_rx},      {24'd0, mdata});
            checkOutput("frame_err", {31'd0, frame_err}, {31'd0, mferr});
            checkOutput("ovr_err",   {31'd0, ovr_err},   {31'd0, moerr});
            checkOutput("par_err",   {31'd0, par_err},   {31'd0, mperr});
            if (vld_rx === 1'b1 && prev_vld !== 1'b1) begin
                vld_rises++;
                last_vld_rise = cyc;
            end
            prev_vld = vld_rx;
            if (ovr_err === 1'b1)   ovr_count++;
            if (frame_err === 1'b1) ferr_count++;
            if (par_err === 1'b1)   perr_count++;
        end
    end

    task automatic idleCycles(input int n, input bit rnd_rdy);
        repeat (n) begin
            @(negedge clk);
            rxd = 1'b1;
            if (rnd_rdy) rdy_rx = 1'($urandom_range(0, 1));
        end
    endtask

    // Serialises one frame, starting at the next falling edge, and records
    // the edge on which its mid-stop decision falls.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_bit,
                                 input bit par_flip, input bit rnd_rdy);
        logic [NBITS-1:0] bits;
        frame_t f;
`ifdef UART_RX_PARITY_EN
        bits = {stop_bit, (^data) ^ par_flip, data, 1'b0};
`else
        bits = {stop_bit, data, 1'b0};
`endif
        @(negedge clk);
        f.due     = cyc + LAT;
        f.data    = data;
        f.stop_ok = stop_bit;
        f.par_ok  = !par_flip;
        pend.push_back(f);
        last_start = cyc;
        for (int b = 0; b < NBITS; b++) begin
            for (int s = 0; s < 16; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                rxd = bits[b];
                if (rnd_rdy) rdy_rx = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic acceptOne();
        @(negedge clk);
        rdy_rx = 1'b1;
        @(negedge clk);
        rdy_rx = 1'b0;
    endtask

    initial begin
        int r0, o0, f0, p0;
        logic [7:0] partial;

        // Reset and quiet line
        rst = 1'b1;
        rxd = 1'b1;
        rdy_rx = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        checking_on = 1'b1;
        @(negedge clk);
        checkOutput("reset_d_rx", {24'd0, d_rx}, 32'h00);
        checkOutput("reset_vld", {31'd0, vld_rx}, 32'd0);
        checkOutput("reset_errs", {29'd0, frame_err, ovr_err, par_err}, 32'd0);
        idleCycles(1000, 1'b0);
        checkOutput("idle_vld_rises", vld_rises, 32'd0);
        checkOutput("idle_ferr", ferr_count, 32'd0);

        // Single byte, latency and hold until accepted
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
        checkOutput("latency", last_vld_rise - last_start, LAT);
        idleCycles(20, 1'b0);
        checkOutput("held_vld", {31'd0, vld_rx}, 32'd1);
        checkOutput("held_data", {24'd0, d_rx}, 32'hA5);
        acceptOne();
        checkOutput("accept_clears", {31'd0, vld_rx}, 32'd0);

        // Back-to-back frames with consumer always ready
        rdy_rx = 1'b1;
        r0 = vld_rises;
        o0 = ovr_count;
        p0 = perr_count;
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h0F, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b1, 1'b0, 1'b0);
        idleCycles(20, 1'b0);
        checkOutput("b2b_count", vld_rises - r0, 32'd3);
        checkOutput("b2b_ovr", ovr_count - o0, 32'd0);
        checkOutput("b2b_perr", perr_count - p0, 32'd0);
        checkOutput("b2b_last", {24'd0, d_rx}, 32'hF0);

        // Overrun keeps the held byte
        rdy_rx = 1'b0;
        o0 = ovr_count;
        r0 = vld_rises;
        applyStimulus(8'h11, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0, 1'b0);
        idleCycles(10, 1'b0);
        checkOutput("ovr_pulse", ovr_count - o0, 32'd1);
        checkOutput("ovr_keep", {24'd0, d_rx}, 32'h11);
        acceptOne();
        idleCycles(100, 1'b0);
        checkOutput("ovr_one_byte", vld_rises - r0, 32'd1);
        checkOutput("ovr_empty", {31'd0, vld_rx}, 32'd0);

        // Framing error, then a short glitch that must be ignored
        f0 = ferr_count;
        r0 = vld_rises;
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
        idleCycles(32, 1'b0);
        checkOutput("ferr_pulse", ferr_count - f0, 32'd1);
        checkOutput("ferr_no_vld", vld_rises - r0, 32'd0);
        repeat (6) begin
            @(negedge clk);
            rxd = 1'b0;
        end
        idleCycles(200, 1'b0);
        checkOutput("glitch_ferr", ferr_count - f0, 32'd1);
        checkOutput("glitch_vld", vld_rises - r0, 32'd0);

`ifdef UART_RX_PARITY_EN
        // Parity good and bad
        applyStimulus(8'h03, 1'b1, 1'b0, 1'b0);
        idleCycles(10, 1'b0);
        checkOutput("par_ok_data", {24'd0, d_rx}, 32'h03);
        checkOutput("par_ok_vld", {31'd0, vld_rx}, 32'd1);
        acceptOne();
        p0 = perr_count;
        r0 = vld_rises;
        applyStimulus(8'h03, 1'b1, 1'b1, 1'b0);
        idleCycles(10, 1'b0);
        checkOutput("par_bad_pulse", perr_count - p0, 32'd1);
        checkOutput("par_bad_no_vld", vld_rises - r0, 32'd0);
`endif

        // Reset in the middle of a frame discards partial and held bytes
        applyStimulus(8'h99, 1'b1, 1'b0, 1'b0);
        idleCycles(5, 1'b0);
        checkOutput("pre_rst_held", {31'd0, vld_rx}, 32'd1);
        partial = 8'h5A;
        for (int b = 0; b < 5; b++) begin
            repeat (16) begin
                @(negedge clk);
                rxd = (b == 0) ? 1'b0 : partial[b-1];
            end
        end
        @(negedge clk);
        rxd = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_vld", {31'd0, vld_rx}, 32'd0);
        checkOutput("rst_d_rx", {24'd0, d_rx}, 32'h00);
        applyStimulus(8'h7E, 1'b1, 1'b0, 1'b0);
        idleCycles(5, 1'b0);
        checkOutput("post_rst_data", {24'd0, d_rx}, 32'h7E);
        checkOutput("post_rst_vld", {31'd0, vld_rx}, 32'd1);
        acceptOne();

        // Randomised traffic with a randomly stalling consumer
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            bit stop_ok;
            bit flip;
            d = 8'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
            flip = ($urandom_range(0, 7) == 0);
`else
            flip = 1'b0;
`endif
            applyStimulus(d, stop_ok, flip, 1'b1);
            if (stop_ok) idleCycles($urandom_range(0, 20), 1'b1);
            else         idleCycles(20 + $urandom_range(0, 10), 1'b1);
        end
        rdy_rx = 1'b1;
        idleCycles(10, 1'b0);
        checkOutput("drain_vld", {31'd0, vld_rx}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
